mem_event_packer: RTL and testbench
===================================

# mem_event_packer

Sits between the core's raw data-memory bus and the commit checker, upstream of the checker's mem_read/mem_write ports. Captures each load/store request at issue, completes loads with the next-cycle response data, and holds them in a small in-order FIFO. When the matching load/store instruction commits, presents the access as a checker memory event: address, width in bits and right-aligned data. Also flags ordering violations between memory traffic and commits.

## Interface
- DEPTH, 2: FIFO entries, power of two, minimum 2.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- dmem_valid  in  1  core issues a data access this cycle.
- dmem_addr  in  32  byte address of the access.
- dmem_wstrb  in  4  byte strobes; 0 = load, non-zero = store.
- dmem_wdata  in  32  store data, lane-aligned.
- dmem_rdata  in  32  load data, lane-aligned; valid exactly one cycle after the load request.
- commit_valid  in  1  an instruction commits this cycle.
- commit_inst  in  32  committed instruction word.
- mem_read_valid  out  1  committed load event.
- mem_read_addr  out  32  load byte address.
- mem_read_memWidth  out  7  8, 16 or 32.
- mem_read_data  out  32  loaded bytes, shifted to bit 0, zero-filled above width.
- mem_write_valid / mem_write_addr / mem_write_memWidth / mem_write_data  out  1/32/7/32  same fields for stores.
- err  out  1  sticky ordering-violation flag.

## Operation
- Push: dmem_valid=1 writes {addr, is_store, width, data, data_ok} at the tail.
  - Store: width = 8 × popcount(wstrb); data = wdata >> (8 × addr[1:0]), masked to width; data_ok=1.
  - Load: width from commit decode later; data_ok=0. Next cycle, dmem_rdata is latched into that entry and data_ok is set.
- Pop: commit_valid=1 with opcode 0000011 (load) or 0100011 (store) pops the head. All other commits are ignored.
  - Load width from funct3[1:0]: 00→8, 01→16, 10→32.
  - Load data = latched word >> (8 × addr[1:0]), masked to width. The sign bit is not extended.
- Events: drive mem_read_* (head is a load) or mem_write_* (head is a store) in the pop cycle only. Outputs decode combinationally from the head register and commit_valid. Valids are 0 in all other cycles.
- Bypass: if the popped head is a load whose response arrives this same cycle, mem_read_data uses dmem_rdata directly.
- err is set, and never cleared except by reset, on any of:
  - push when the FIFO is full (the push is dropped);
  - pop when the FIFO is empty (no event is driven);
  - popped head type does not match the commit opcode (the event is still driven, typed by the head);
  - pop of a load with data_ok=0 and no bypass (the event is driven with data 0).
- Simultaneous push and pop in one cycle is legal at any occupancy except empty. When empty, pop-underflow is flagged and the push still lands.
- Head and tail pointers are log2(DEPTH)+1 bits and wrap modulo 2×DEPTH. Full/empty are detected by pointer MSB compare.

## Timing
- Reset (reset=0): pointers 0, all data_ok 0, err 0, every output valid 0, all output data/addr/width fields 0.
- Push to entry visible at head: 1 cycle.
- Load response latch: the cycle after the request edge.
- Commit to event: 0 cycles, same cycle as commit_valid.
- Reset deasserted mid-operation: the FIFO is empty on the first active edge. A load response in flight at that edge is discarded.

## Configuration
- MEM_EVENT_PACKER_ASSERT_EN defined:
  - Immediate assertions, active when reset=1, that each err condition never occurs.
  - An assume that dmem_wstrb is one of 0001<<k, 0011<<2k or 1111, aligned to addr[1:0]. This lets formal runs prove ordering alongside the checker.
- MEM_EVENT_PACKER_ASSERT_EN undefined: no assertions or assumptions are compiled. err is the only indication of a violation.

## Test plan
- Store: SW, addr 0x100, wstrb 1111, wdata 0xDEADBEEF. Commit 2 cycles later → mem_write_valid=1, addr 0x100, width 32, data 0xDEADBEEF. err=0.
- Byte load: LBU, addr 0x203, rdata 0xAABBCCDD next cycle. Commit funct3=100 → mem_read_data 0x000000AA, width 8.
- Bypass: LH at addr 0x2, commit in the response cycle with rdata 0x12345678 → data 0x00001234, width 16. err=0.
- Overflow: DEPTH=2, three pushes with no commits → err=1 on the third edge. The first two entries still pop correctly.
- Underflow: commit of LW with an empty FIFO → no valid asserted, err=1.
- Async reset: assert reset=0 mid-stream with 2 entries queued → all outputs 0 immediately. After release, a fresh SB at 0x11 with wstrb 0010 and wdata 0x0000EE00 → write data 0xEE, width 8.

Source files
------------

// File: rtl/mem_event_packer.sv
// mem_event_packer: captures data-memory requests at issue, completes loads
// with the next-cycle response, and emits checker memory events in commit order.
// Optional build macro: MEM_EVENT_PACKER_ASSERT_EN enables immediate assertions
// on every ordering-violation condition plus an assume on legal store strobes.
// Handshake note: dmem_valid and commit_valid are single-cycle strobes with no
// back-pressure; mem_read_valid/mem_write_valid are combinational and last
// exactly the commit cycle.
module mem_event_packer #(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        commit_valid,
    input  logic [31:0] commit_inst,
    output logic        mem_read_valid,
    output logic [31:0] mem_read_addr,
    output logic [6:0]  mem_read_memWidth,
    output logic [31:0] mem_read_data,
    output logic        mem_write_valid,
    output logic [31:0] mem_write_addr,
    output logic [6:0]  mem_write_memWidth,
    output logic [31:0] mem_write_data,
    output logic        err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;

    logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0][31:0]   addr_q, addr_d;
    logic [DEPTH-1:0][31:0]   data_q, data_d;
    logic [DEPTH-1:0][6:0]    width_q, width_d;
    logic [DEPTH-1:0]         store_q, store_d;
    logic [DEPTH-1:0]         ok_q, ok_d;
    logic                     pend_q, pend_d;
    logic [AW-1:0]            pend_idx_q, pend_idx_d;
    logic                     err_q, err_d;

    logic [AW-1:0] head_idx, tail_idx;
    logic          empty, full;
    logic          is_ld_op, is_st_op, pop_req, pop_ok, push_ok;
    logic          h_store, bypass, ld_ok;
    logic [4:0]    h_shift, st_shift;
    logic [6:0]    ld_width, st_width;
    logic [31:0]   ld_word, ld_data, st_data;
    logic          ovf_err, unf_err, type_err, nodata_err;
    logic          unused_inst;

    // Only opcode and the size bits of funct3 matter to this block.
    assign unused_inst = ^{commit_inst[31:14], commit_inst[11:7]};

    function automatic logic [31:0] width_mask(input logic [6:0] w);
        if (w >= 7'd32) return 32'hFFFF_FFFF;
        return (32'h1 << w) - 32'h1;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] s);
        return {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
    endfunction

    // Event decode, error detection and FIFO next-state.
    always_comb begin
        head_idx   = head_q[AW-1:0];
        tail_idx   = tail_q[AW-1:0];
        empty      = (head_q == tail_q);
        full       = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);

        is_ld_op   = (commit_inst[6:0] == 7'b0000011);
        is_st_op   = (commit_inst[6:0] == 7'b0100011);
        pop_req    = commit_valid && (is_ld_op || is_st_op);
        pop_ok     = pop_req && !empty;
        push_ok    = dmem_valid && (!full || pop_ok);

        h_store    = store_q[head_idx];
        bypass     = pend_q && (pend_idx_q == head_idx) && !h_store;
        h_shift    = {addr_q[head_idx][1:0], 3'b000};
        case (commit_inst[13:12])
            2'b00:   ld_width = 7'd8;
            2'b01:   ld_width = 7'd16;
            default: ld_width = 7'd32;
        endcase
        ld_word    = bypass ? dmem_rdata : data_q[head_idx];
        ld_ok      = ok_q[head_idx] || bypass;
        ld_data    = ld_ok ? ((ld_word >> h_shift) & width_mask(ld_width)) : 32'h0;

        st_shift   = {dmem_addr[1:0], 3'b000};
        st_width   = {1'b0, popcount4(dmem_wstrb), 3'b000};
        st_data    = (dmem_wdata >> st_shift) & width_mask(st_width);

        mem_read_valid     = 1'b0;
        mem_read_addr      = 32'h0;
        mem_read_memWidth  = 7'd0;
        mem_read_data      = 32'h0;
        mem_write_valid    = 1'b0;
        mem_write_addr     = 32'h0;
        mem_write_memWidth = 7'd0;
        mem_write_data     = 32'h0;
        if (pop_ok) begin
            if (h_store) begin
                mem_write_valid    = 1'b1;
                mem_write_addr     = addr_q[head_idx];
                mem_write_memWidth = width_q[head_idx];
                mem_write_data     = data_q[head_idx];
            end else begin
                mem_read_valid     = 1'b1;
                mem_read_addr      = addr_q[head_idx];
                mem_read_memWidth  = ld_width;
                mem_read_data      = ld_data;
            end
        end

        ovf_err    = dmem_valid && full && !pop_ok;
        unf_err    = pop_req && empty;
        type_err   = pop_ok && (h_store != is_st_op);
        nodata_err = pop_ok && !h_store && !ld_ok;
        err_d      = err_q || ovf_err || unf_err || type_err || nodata_err;

        head_d     = head_q;
        tail_d     = tail_q;
        addr_d     = addr_q;
        data_d     = data_q;
        width_d    = width_q;
        store_d    = store_q;
        ok_d       = ok_q;
        // Response latch goes first so a push reusing the same slot wins.
        if (pend_q) begin
            data_d[pend_idx_q] = dmem_rdata;
            ok_d[pend_idx_q]   = 1'b1;
        end
        if (pop_ok) head_d = head_q + 1'b1;
        if (push_ok) begin
            addr_d[tail_idx]  = dmem_addr;
            store_d[tail_idx] = (dmem_wstrb != 4'b0000);
            width_d[tail_idx] = (dmem_wstrb != 4'b0000) ? st_width : 7'd0;
            data_d[tail_idx]  = (dmem_wstrb != 4'b0000) ? st_data : 32'h0;
            ok_d[tail_idx]    = (dmem_wstrb != 4'b0000);
            tail_d            = tail_q + 1'b1;
        end
        pend_d     = push_ok && (dmem_wstrb == 4'b0000);
        pend_idx_d = tail_idx;
    end

    assign err = err_q;

    // State register; reset empties the FIFO and drops any in-flight response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            width_q    <= '0;
            store_q    <= '0;
            ok_q       <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            width_q    <= width_d;
            store_q    <= store_d;
            ok_q       <= ok_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            err_q      <= err_d;
        end
    end

`ifdef MEM_EVENT_PACKER_ASSERT_EN
    // Each ordering violation is illegal; stores use naturally aligned strobes.
    always @(posedge clock) begin
        if (reset) begin
            assert (!ovf_err);
            assert (!unf_err);
            assert (!type_err);
            assert (!nodata_err);
            if (dmem_valid && (dmem_wstrb != 4'b0000))
                assume ((dmem_wstrb == (4'b0001 << dmem_addr[1:0])) ||
                        ((dmem_wstrb == (4'b0011 << dmem_addr[1:0])) && !dmem_addr[0]) ||
                        ((dmem_wstrb == 4'b1111) && (dmem_addr[1:0] == 2'b00)));
        end
    end
`endif

endmodule

// File: tb/tb_mem_event_packer.sv
// Randomized scoreboard bench for mem_event_packer: a queue-based model of the
// in-order access list predicts each commit event and the sticky error flag.
module tb_mem_event_packer;
    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        commit_valid;
    logic [31:0] commit_inst;
    logic        mem_read_valid, mem_write_valid, err;
    logic [31:0] mem_read_addr, mem_read_data, mem_write_addr, mem_write_data;
    logic [6:0]  mem_read_memWidth, mem_write_memWidth;

    mem_event_packer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .commit_valid(commit_valid), .commit_inst(commit_inst),
        .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
        .mem_read_memWidth(mem_read_memWidth), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_addr(mem_write_addr),
        .mem_write_memWidth(mem_write_memWidth), .mem_write_data(mem_write_data),
        .err(err)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic        is_store;
        logic [6:0]  width;
        logic [31:0] data;
        logic        ok;
        int          id;
    } ent_t;

    ent_t        mq[$];
    int          next_id = 0;
    bit          pend = 0;
    int          pend_id = 0;
    bit          model_err = 0;
    bit          err_vis = 0;
    logic [71:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] op);
        return {17'h0, f3, 5'h0, op};
    endfunction

    // n bytes of w starting at byte lane lo, right-aligned, zero beyond lane 3.
    function automatic logic [31:0] pick_bytes(input logic [31:0] w, input int lo, input int n);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < n; i++)
            if (lo + i < 4) r[8*i +: 8] = w[8*(lo+i) +: 8];
        return r;
    endfunction

    function automatic int ones(input logic [3:0] s);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) if (s[i]) c++;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // ---------------- driver: one cycle of stimulus plus model update ----------------
    task automatic step(input bit dv, input logic [31:0] a, input logic [3:0] ws,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input bit cv, input logic [31:0] ci);
        ent_t h, e;
        int   occ, n;
        bit   pop, popped;
        logic [31:0] d;
        @(posedge clock); #1;
        err_vis      = model_err;
        dmem_valid   = dv;
        dmem_addr    = a;
        dmem_wstrb   = ws;
        dmem_wdata   = wd;
        dmem_rdata   = rd;
        commit_valid = cv;
        commit_inst  = ci;
        // a load response arriving this cycle completes its entry immediately
        if (pend)
            foreach (mq[i]) if (mq[i].id == pend_id) begin
                mq[i].data = rd;
                mq[i].ok   = 1'b1;
            end
        occ    = mq.size();
        pop    = cv && (ci[6:0] == OP_LD || ci[6:0] == OP_ST);
        popped = 0;
        if (pop) begin
            if (occ == 0) model_err = 1;
            else begin
                h = mq.pop_front();
                popped = 1;
                if (h.is_store != (ci[6:0] == OP_ST)) model_err = 1;
                if (h.is_store) exp_q.push_back({1'b1, h.addr, h.width, h.data});
                else begin
                    n = (ci[13:12] == 2'b00) ? 1 : (ci[13:12] == 2'b01) ? 2 : 4;
                    d = h.ok ? pick_bytes(h.data, int'(h.addr[1:0]), n) : 32'h0;
                    if (!h.ok) model_err = 1;
                    exp_q.push_back({1'b0, h.addr, 7'(8*n), d});
                end
            end
        end
        pend = 0;
        if (dv) begin
            if (occ == DEPTH && !popped) model_err = 1;
            else begin
                e.addr     = a;
                e.is_store = (ws != 4'b0000);
                e.width    = 7'(8 * ones(ws));
                e.data     = e.is_store ? pick_bytes(wd, int'(a[1:0]), ones(ws)) : 32'h0;
                e.ok       = e.is_store;
                e.id       = next_id++;
                mq.push_back(e);
                if (!e.is_store) begin
                    pend    = 1;
                    pend_id = e.id;
                end
            end
        end
    endtask

    task automatic idle();
        step(0, 32'h0, 4'h0, 32'h0, $urandom, 0, 32'h0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        logic [71:0] got, want;
        if (reset) begin
            n_cmp++;
            if (err !== err_vis) begin
                n_bad++;
                $display("FAIL err_flag: got %b required %b", err, err_vis);
            end
            if (mem_read_valid || mem_write_valid) begin
                got = mem_write_valid
                    ? {1'b1, mem_write_addr, mem_write_memWidth, mem_write_data}
                    : {1'b0, mem_read_addr, mem_read_memWidth, mem_read_data};
                n_cmp++;
                if (mem_read_valid && mem_write_valid) begin
                    n_bad++;
                    $display("FAIL both_valid: read and write events together");
                end else if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got %h required none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_bad++;
                        $display("FAIL event: got st=%b a=%h w=%0d d=%h required st=%b a=%h w=%0d d=%h",
                                 got[71], got[70:39], got[38:32], got[31:0],
                                 want[71], want[70:39], want[38:32], want[31:0]);
                    end
                end
            end else if (exp_q.size() > 0) begin
                n_cmp++;
                n_bad++;
                want = exp_q.pop_front();
                $display("FAIL missing_event: got none required %h", want);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int sz, occ;
        bit cv, dv;
        logic [31:0] a, ci;
        logic [3:0]  ws;
        logic [2:0]  f3;

        reset = 1'b0;
        dmem_valid = 0; dmem_addr = 0; dmem_wstrb = 0; dmem_wdata = 0; dmem_rdata = 0;
        commit_valid = 1'b1; commit_inst = mk_inst(3'b010, OP_LD);
        #12;
        chk("reset_outputs",
            {31'h0, mem_read_valid, mem_write_valid, err}, 32'h0);
        chk("reset_read_fields", mem_read_addr | mem_read_data | {25'h0, mem_read_memWidth}, 32'h0);
        commit_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b1;

        // SW 0x100
        step(1, 32'h100, 4'hF, 32'hDEADBEEF, $urandom, 0, 32'h0);
        idle(); idle();
        step(0, 32'h0, 4'h0, 32'h0, $urandom, 1, mk_inst(3'b010, OP_ST));
        #1 chk("sw_data", mem_write_data, 32'hDEADBEEF);
        chk("sw_width", {25'h0, mem_write_memWidth}, 32'd32);

        // LBU 0x203
        step(1, 32'h203, 4'h0, 32'h0, $urandom, 0, 32'h0);
        step(0, 32'h0, 4'h0, 32'h0, 32'hAABBCCDD, 0, 32'h0);
        step(0, 32'h0, 4'h0, 32'h0, $urandom, 1, mk_inst(3'b100, OP_LD));
        #1 chk("lbu_data", mem_read_data, 32'h000000AA);

        // LH bypass at 0x2
        step(1, 32'h2, 4'h0, 32'h0, $urandom, 0, 32'h0);
        step(0, 32'h0, 4'h0, 32'h0, 32'h12345678, 1, mk_inst(3'b001, OP_LD));
        #1 chk("lh_bypass_data", mem_read_data, 32'h00001234);
        chk("lh_bypass_width", {25'h0, mem_read_memWidth}, 32'd16);
        idle();

        // legal random traffic
        for (int c = 0; c < 600; c++) begin
            occ = mq.size();
            cv  = (occ > 0) && ($urandom_range(0, 1) == 1);
            dv  = (occ < DEPTH || cv) && ($urandom_range(0, 2) != 0);
            ci  = mk_inst(3'($urandom_range(0, 7)), OP_ALU);
            if (cv) begin
                if (mq[0].is_store)
                    ci = mk_inst(mq[0].width == 7'd8 ? 3'b000 : mq[0].width == 7'd16 ? 3'b001 : 3'b010, OP_ST);
                else begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                        3: f3 = 3'b100; default: f3 = 3'b101;
                    endcase
                    ci = mk_inst(f3, OP_LD);
                end
            end
            a  = $urandom;
            ws = 4'h0;
            if ($urandom_range(0, 1) == 1) begin
                sz = 1 << $urandom_range(0, 2);
                a  = a & ~32'(sz - 1);
                ws = 4'(((1 << sz) - 1) << a[1:0]);
            end
            step(dv, a, ws, $urandom, $urandom, cv || ($urandom_range(0, 3) == 0), ci);
        end
        while (mq.size() > 0)
            step(0, 32'h0, 4'h0, 32'h0, $urandom, 1,
                 mk_inst(mq[0].is_store ? (mq[0].width == 7'd8 ? 3'b000 : mq[0].width == 7'd16 ? 3'b001 : 3'b010)
                                        : 3'b010, mq[0].is_store ? OP_ST : OP_LD));
        idle();
        chk("err_clean_after_random", {31'h0, err}, 32'h0);

        // overflow: three pushes into DEPTH=2
        step(1, 32'h40, 4'hF, 32'h11111111, $urandom, 0, 32'h0);
        step(1, 32'h44, 4'hF, 32'h22222222, $urandom, 0, 32'h0);
        step(1, 32'h48, 4'hF, 32'h33333333, $urandom, 0, 32'h0);
        idle();
        #1 chk("overflow_err", {31'h0, err}, 32'h1);
        step(0, 32'h0, 4'h0, 32'h0, $urandom, 1, mk_inst(3'b010, OP_ST));
        #1 chk("overflow_first", mem_write_data, 32'h11111111);
        step(0, 32'h0, 4'h0, 32'h0, $urandom, 1, mk_inst(3'b010, OP_ST));
        #1 chk("overflow_second", mem_write_data, 32'h22222222);

        // async reset with two entries queued, one load response in flight
        step(1, 32'h80, 4'hF, 32'h55555555, $urandom, 0, 32'h0);
        step(1, 32'h84, 4'h0, 32'h0, $urandom, 0, 32'h0);
        @(posedge clock); #1;
        dmem_valid = 0; dmem_rdata = 32'h99999999;
        commit_valid = 1'b1; commit_inst = mk_inst(3'b010, OP_ST);
        #1 reset = 1'b0;
        #1 chk("async_reset_valids", {30'h0, mem_read_valid, mem_write_valid}, 32'h0);
        chk("async_reset_err", {31'h0, err}, 32'h0);
        chk("async_reset_fields", mem_write_addr | mem_write_data | {25'h0, mem_write_memWidth}, 32'h0);
        mq.delete(); pend = 0; model_err = 0; err_vis = 0;
        commit_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        step(1, 32'h11, 4'b0010, 32'h0000EE00, $urandom, 0, 32'h0);
        step(0, 32'h0, 4'h0, 32'h0, $urandom, 1, mk_inst(3'b000, OP_ST));
        #1 chk("post_reset_sb_data", mem_write_data, 32'h000000EE);
        chk("post_reset_sb_width", {25'h0, mem_write_memWidth}, 32'd8);

        // underflow
        idle();
        step(0, 32'h0, 4'h0, 32'h0, $urandom, 1, mk_inst(3'b010, OP_LD));
        #1 chk("underflow_no_valid", {30'h0, mem_read_valid, mem_write_valid}, 32'h0);
        idle();
        #1 chk("underflow_err", {31'h0, err}, 32'h1);
        idle(); idle();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
